// File: rtl/sdram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdram_pkg                                                        |
// | Purpose : Shared definitions for the SDRAM pattern test master: bus        |
// |           widths, FSM state encoding and the test-pattern function.        |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package sdram_pkg;

  localparam int ADDR_W  = 28;          // byte address width
  localparam int DATA_W  = 32;          // data word width
  localparam int WADDR_W = ADDR_W - 2;  // word address width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Pattern for word index idx (idx already zero-extended to DATA_W).
  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                input logic [DATA_W-1:0] idx);
    return seed ^ idx ^ {idx[15:0], idx[15:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdram_pattern_checker                                            |
// | Purpose : In-order compare of returned read data against the expected      |
// |           pattern; keeps a saturating error count and the byte address     |
// |           of the first mismatching word.                                   |
// | Ports   : clk, rst        clock / synchronous active-high reset            |
// |           clear           restart a test (clears count, latch, index)      |
// |           seed, base_word latched test parameters                          |
// |           rsp_valid/data  qualified read response                          |
// |           err_count       saturating mismatch count                        |
// |           first_err_addr  byte address of first mismatch                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sdram_pattern_checker
  import sdram_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [DATA_W-1:0]  seed,
  input  logic [WADDR_W-1:0] base_word,
  input  logic               rsp_valid,
  input  logic [DATA_W-1:0]  rsp_data,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  first_err_addr
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]   r_ret_idx;
  logic [DATA_W-1:0]  w_expected;
  logic               w_mismatch;
  logic [WADDR_W-1:0] w_ret_word;

  assign w_expected = pattern(seed, DATA_W'(r_ret_idx));
  assign w_mismatch = rsp_valid && (rsp_data != w_expected);
  // Word address wraps naturally at the word-address width.
  assign w_ret_word = base_word + WADDR_W'(r_ret_idx);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_ret_idx      <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (rsp_valid) begin
        r_ret_idx <= r_ret_idx + ONE;
      end
      if (w_mismatch) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
        // The count never returns to zero, so zero means "no error latched yet".
        if (err_count == 16'd0) begin
          first_err_addr <= {w_ret_word, 2'b00};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_pattern_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdram_pattern_master                                             |
// | Purpose : Writes a seeded pattern over a word range through an Avalon-MM   |
// |           master, reads it back with up to MAX_PEND reads outstanding and  |
// |           reports pass/fail, error count and first failing address.        |
// | Ports   : clk_clk, reset_reset   clock / synchronous active-high reset     |
// |           start, base_addr, word_count, seed   test request + parameters   |
// |           busy, done, pass, err_count, first_err_addr   test status        |
// |           sdout_*                 Avalon-MM master (single-word accesses)   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sdram_pattern_master
  import sdram_pkg::*;
#(
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] sdout_address,
  output logic              sdout_read,
  output logic              sdout_write,
  output logic [DATA_W-1:0] sdout_writedata,
  output logic [3:0]        sdout_byteenable,
  output logic              sdout_burstcount,
  output logic              sdout_debugaccess,
  input  logic              sdout_waitrequest,
  input  logic [DATA_W-1:0] sdout_readdata,
  input  logic              sdout_readdatavalid
);

  localparam logic [3:0]       PEND_MAX = 4'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [WADDR_W-1:0] r_base_word;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_seed;
  logic [CNT_W-1:0]   r_idx;       // issue index, shared by WRITE and READ
  logic [3:0]         r_pending;   // accepted reads awaiting data

  logic               w_start_ok, w_wr_acc, w_rd_req, w_rd_acc, w_rsp_valid, w_last_idx;
  logic [WADDR_W-1:0] w_word_addr;
  logic               unused_addr_lsbs;

  assign unused_addr_lsbs = ^base_addr[1:0];

  assign sdout_byteenable  = 4'hF;
  assign sdout_burstcount  = 1'b1;
  assign sdout_debugaccess = 1'b0;

  assign w_start_ok  = (r_state == IDLE) && start;
  assign w_wr_acc    = (r_state == WRITE) && !sdout_waitrequest;
  assign w_rd_req    = (r_state == READ) && (r_pending < PEND_MAX);
  assign w_rd_acc    = w_rd_req && !sdout_waitrequest;
  // Responses with nothing outstanding are stray and dropped here.
  assign w_rsp_valid = sdout_readdatavalid && (r_pending != 4'd0);
  assign w_last_idx  = (r_idx == r_count - ONE);
  assign w_word_addr = r_base_word + WADDR_W'(r_idx);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus command outputs are decoded from state so a reset removes them at once.
  always_comb begin
    w_state_nxt     = r_state;
    sdout_write     = 1'b0;
    sdout_read      = 1'b0;
    sdout_address   = '0;
    sdout_writedata = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (word_count == '0) ? FIN : WRITE;
        end
      end
      WRITE: begin
        sdout_write     = 1'b1;
        sdout_address   = {w_word_addr, 2'b00};
        sdout_writedata = pattern(r_seed, DATA_W'(r_idx));
        if (w_wr_acc && w_last_idx) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        sdout_read    = w_rd_req;
        sdout_address = {w_word_addr, 2'b00};
        if (w_rd_acc && w_last_idx) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_pending == 4'd0) begin
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_base_word <= '0;
      r_count     <= '0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_pending   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_base_word <= base_addr[ADDR_W-1:2];
        r_count     <= word_count;
        r_seed      <= seed;
        r_idx       <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
      end
      if (w_wr_acc) begin
        r_idx <= w_last_idx ? '0 : r_idx + ONE;
      end
      if (w_rd_acc) begin
        r_idx <= r_idx + ONE;
      end
      case ({w_rd_acc, w_rsp_valid})
        2'b10:   r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
      if (r_state == FIN) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == 16'd0);
      end
    end
  end

  sdram_pattern_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk            (clk_clk),
    .rst            (reset_reset),
    .clear          (w_start_ok),
    .seed           (r_seed),
    .base_word      (r_base_word),
    .rsp_valid      (w_rsp_valid),
    .rsp_data       (sdout_readdata),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sdram_pattern_master                                          |
// | Purpose : Scoreboard bench for sdram_pattern_master with a configurable    |
// |           Avalon memory model (stalls, read latency, corruption).          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sdram_pattern_master;

  localparam int TB_MAX_PEND = 4;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] base_addr = '0;
  logic [23:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [27:0] first_err_addr, sdout_address;
  logic        sdout_read, sdout_write, sdout_burstcount, sdout_debugaccess;
  logic [31:0] sdout_writedata, sdout_readdata;
  logic [3:0]  sdout_byteenable;
  logic        sdout_waitrequest, sdout_readdatavalid;

  always #5 clk_clk = ~clk_clk;

  sdram_pattern_master #(.MAX_PEND(TB_MAX_PEND), .CNT_W(24)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .sdout_address(sdout_address),
    .sdout_read(sdout_read), .sdout_write(sdout_write),
    .sdout_writedata(sdout_writedata), .sdout_byteenable(sdout_byteenable),
    .sdout_burstcount(sdout_burstcount), .sdout_debugaccess(sdout_debugaccess),
    .sdout_waitrequest(sdout_waitrequest), .sdout_readdata(sdout_readdata),
    .sdout_readdatavalid(sdout_readdatavalid)
  );

  // ---------------- memory model ----------------
  typedef struct packed { logic [31:0] data; logic [31:0] due; } rsp_t;
  logic [31:0] mem     [logic [25:0]];
  logic [31:0] corrupt [logic [25:0]];
  rsp_t        rq[$];
  int          stall_cfg = 0;
  int          lat_cfg = 1;
  int          wcnt = 0;
  logic [31:0] cyc = '0;
  logic        m_rdv = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        stray = 1'b0;
  logic        cmd;

  assign cmd                 = sdout_read | sdout_write;
  assign sdout_waitrequest   = cmd && (wcnt < stall_cfg);
  assign sdout_readdatavalid = m_rdv | stray;
  assign sdout_readdata      = stray ? 32'hDEADBEEF : m_rdata;

  always @(posedge clk_clk) begin
    logic [25:0] k;
    logic [31:0] d;
    cyc <= cyc + 32'd1;
    if (reset_reset) begin
      wcnt  <= 0;
      m_rdv <= 1'b0;
      rq.delete();
    end else begin
      k = sdout_address[27:2];
      if (cmd) begin
        if (sdout_waitrequest) begin
          wcnt <= wcnt + 1;
        end else begin
          wcnt <= 0;
          if (sdout_write) begin
            mem[k] = sdout_writedata;
          end else begin
            d = mem.exists(k) ? mem[k] : 32'h0;
            if (corrupt.exists(k)) d = d ^ corrupt[k];
            rq.push_back({d, cyc + 32'(lat_cfg)});
          end
        end
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        m_rdv   <= 1'b1;
        m_rdata <= rq[0].data;
        void'(rq.pop_front());
      end else begin
        m_rdv <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic ok; logic [15:0] ne; logic [27:0] fa; } res_t;
  logic [27:0] exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [27:0] exp_raddr_q[$];
  res_t        exp_res_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  function automatic logic [31:0] tb_pat(input logic [31:0] s, input int i);
    logic [31:0] v;
    v = 32'(i);
    return s ^ v ^ ((v & 32'h0000_FFFF) * 32'h0001_0001);
  endfunction

  function automatic logic [27:0] tb_addr(input logic [27:0] b, input int i);
    return ((b & 28'hFFFFFFC) + 28'(4 * i)) & 28'hFFFFFFF;
  endfunction

  task automatic push_word(input logic [27:0] a, input logic [31:0] d);
    exp_waddr_q.push_back(a);
    exp_wdata_q.push_back(d);
    exp_raddr_q.push_back(a);
  endtask

  task automatic push_model(input logic [27:0] b, input int n, input logic [31:0] s);
    for (int i = 0; i < n; i++) push_word(tb_addr(b, i), tb_pat(s, i));
  endtask

  task automatic push_result(input logic ok, input logic [15:0] ne, input logic [27:0] fa);
    exp_res_q.push_back({ok, ne, fa});
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT acts.
  int          outst = 0;
  int          max_outst = 0;
  logic        prev_stall = 1'b0, prev_done = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [27:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always @(negedge clk_clk) begin
    logic acc_rd, dec;
    res_t r;
    if (reset_reset) begin
      outst      <= 0;
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      acc_rd = sdout_read && !sdout_waitrequest;
      dec    = sdout_readdatavalid && (outst > 0);
      if (cmd) check("rw_exclusive", {31'd0, sdout_read & sdout_write}, 32'd0);
      if (prev_stall) begin
        check("stall_addr", {4'd0, sdout_address}, {4'd0, prev_addr});
        check("stall_wdata", sdout_writedata, prev_wdata);
        check("stall_cmd", {30'd0, sdout_read, sdout_write}, {30'd0, prev_rd, prev_wr});
      end
      if (sdout_write && !sdout_waitrequest) begin
        if (exp_waddr_q.size() == 0) fail("unexpected_write");
        else begin
          check("write_addr", {4'd0, sdout_address}, {4'd0, exp_waddr_q.pop_front()});
          check("write_data", sdout_writedata, exp_wdata_q.pop_front());
        end
      end
      if (acc_rd) begin
        check("pending_limit", 32'(outst < TB_MAX_PEND), 32'd1);
        if (exp_raddr_q.size() == 0) fail("unexpected_read");
        else check("read_addr", {4'd0, sdout_address}, {4'd0, exp_raddr_q.pop_front()});
      end
      if (done && !prev_done) begin
        if (exp_res_q.size() == 0) fail("unexpected_done");
        else begin
          r = exp_res_q.pop_front();
          check("pass", {31'd0, pass}, {31'd0, r.ok});
          check("err_count", {16'd0, err_count}, {16'd0, r.ne});
          check("first_err_addr", {4'd0, first_err_addr}, {4'd0, r.fa});
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      outst      <= outst + int'(acc_rd) - int'(dec);
      if (outst + int'(acc_rd) - int'(dec) > max_outst) max_outst <= outst + int'(acc_rd) - int'(dec);
      prev_stall <= cmd && sdout_waitrequest;
      prev_rd    <= sdout_read;
      prev_wr    <= sdout_write;
      prev_addr  <= sdout_address;
      prev_wdata <= sdout_writedata;
      prev_done  <= done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [27:0] b, input logic [23:0] n, input logic [31:0] s,
                     input int limit);
    int k;
    base_addr  = b;
    word_count = n;
    seed       = s;
    @(posedge clk_clk); #1 start = 1'b1;
    @(posedge clk_clk); #1 start = 1'b0;
    k = 0;
    while (!done && k < limit) begin
      @(posedge clk_clk); #1;
      k++;
    end
    if (!done) $display("FAIL done_timeout: got done=0, expected done=1 within %0d cycles", limit);
    if (!done) begin n_cmp++; n_bad++; end
    @(negedge clk_clk); #1;
    check("writes_left", exp_waddr_q.size(), 32'd0);
    check("reads_left", exp_raddr_q.size(), 32'd0);
    check("results_left", exp_res_q.size(), 32'd0);
  endtask

  // Hand-computed: seed A5A5A5A5, i<8 -> A5A5A5A5 ^ (i << 16).
  logic [31:0] hand_a [8] = '{32'hA5A5A5A5, 32'hA5A4A5A5, 32'hA5A7A5A5, 32'hA5A6A5A5,
                              32'hA5A1A5A5, 32'hA5A0A5A5, 32'hA5A3A5A5, 32'hA5A2A5A5};

  initial begin
    int k;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    check("rst_first", {4'd0, first_err_addr}, 32'd0);
    check("rst_cmd", {30'd0, sdout_read, sdout_write}, 32'd0);
    check("rst_addr", {4'd0, sdout_address}, 32'd0);
    check("rst_wdata", sdout_writedata, 32'd0);
    check("const_be_burst_dbg", {25'd0, sdout_byteenable, sdout_burstcount, sdout_debugaccess},
          32'b1111_1_0);
    reset_reset = 1'b0;

    // Basic run, zero-wait memory.
    for (int i = 0; i < 8; i++) push_word(28'h100 + 28'(4 * i), hand_a[i]);
    push_result(1'b1, 16'd0, 28'd0);
    run(28'h0000100, 24'd8, 32'hA5A5A5A5, 200);

    // Same run with 3 stall cycles on every command.
    stall_cfg = 3;
    for (int i = 0; i < 8; i++) push_word(28'h100 + 28'(4 * i), hand_a[i]);
    push_result(1'b1, 16'd0, 28'd0);
    run(28'h0000100, 24'd8, 32'hA5A5A5A5, 400);
    stall_cfg = 0;

    // Two corrupted words on readback.
    corrupt[26'h042] = 32'h0000_0001;
    corrupt[26'h044] = 32'h0000_0100;
    push_model(28'h0000100, 8, 32'hA5A5A5A5);
    push_result(1'b0, 16'd2, 28'h0000108);
    run(28'h0000100, 24'd8, 32'hA5A5A5A5, 200);
    corrupt.delete();

    // word_count = 0: done two cycles after start, no bus traffic.
    base_addr = 28'h0000200; word_count = 24'd0; seed = 32'h1;
    push_result(1'b1, 16'd0, 28'd0);
    @(posedge clk_clk); #1 start = 1'b1;
    @(posedge clk_clk); #1 start = 1'b0;
    check("cnt0_done_c1", {31'd0, done}, 32'd0);
    @(posedge clk_clk); #1;
    check("cnt0_done_c2", {31'd0, done}, 32'd1);
    check("cnt0_busy_c2", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk_clk);
    #1 check("cnt0_results_left", exp_res_q.size(), 32'd0);

    // Read latency 5: outstanding reads must saturate at MAX_PEND.
    lat_cfg = 5;
    max_outst = 0;
    push_model(28'h0002000, 16, 32'h12345678);
    push_result(1'b1, 16'd0, 28'd0);
    run(28'h0002000, 24'd16, 32'h12345678, 400);
    check("max_pending", max_outst, TB_MAX_PEND);
    lat_cfg = 1;

    // Address wrap at 2^28, plus a stray readdatavalid during WRITE.
    push_word(28'hFFFFFF8, 32'h0000_0000);
    push_word(28'hFFFFFFC, 32'h0001_0000);
    push_word(28'h0000000, 32'h0002_0000);
    push_word(28'h0000004, 32'h0003_0000);
    push_result(1'b1, 16'd0, 28'd0);
    fork
      run(28'hFFFFFF8, 24'd4, 32'h0, 200);
      begin
        repeat (2) @(posedge clk_clk);
        #1 stray = 1'b1;
        @(posedge clk_clk); #1 stray = 1'b0;
      end
    join

    // start while busy (with changed inputs) must be ignored.
    push_model(28'h0000400, 6, 32'hCAFEF00D);
    push_result(1'b1, 16'd0, 28'd0);
    fork
      run(28'h0000400, 24'd6, 32'hCAFEF00D, 200);
      begin
        repeat (8) @(posedge clk_clk);
        #1;
        base_addr = 28'h0000800; word_count = 24'd3; seed = 32'h0; start = 1'b1;
        @(posedge clk_clk); #1 start = 1'b0;
      end
    join

    // Reset asserted mid-READ after an error has been latched.
    corrupt[26'h010] = 32'h0000_0001;
    push_model(28'h0000040, 8, 32'h0F0F0F0F);
    base_addr = 28'h0000040; word_count = 24'd8; seed = 32'h0F0F0F0F;
    @(posedge clk_clk); #1 start = 1'b1;
    @(posedge clk_clk); #1 start = 1'b0;
    k = 0;
    while (!(sdout_read && err_count != 16'd0) && k < 100) begin
      @(posedge clk_clk); #1;
      k++;
    end
    check("midread_reached", {31'd0, sdout_read && err_count != 16'd0}, 32'd1);
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    check("mid_rst_cmd", {30'd0, sdout_read, sdout_write}, 32'd0);
    check("mid_rst_addr", {4'd0, sdout_address}, 32'd0);
    check("mid_rst_wdata", sdout_writedata, 32'd0);
    check("mid_rst_status", {29'd0, busy, done, pass}, 32'd0);
    check("mid_rst_err", {16'd0, err_count}, 32'd0);
    check("mid_rst_first", {4'd0, first_err_addr}, 32'd0);
    exp_waddr_q.delete(); exp_wdata_q.delete(); exp_raddr_q.delete(); exp_res_q.delete();
    corrupt.delete();
    @(posedge clk_clk); #1 reset_reset = 1'b0;

    // Operation after reset.
    push_model(28'h0000000, 1, 32'h1);
    push_result(1'b1, 16'd0, 28'd0);
    run(28'h0000000, 24'd1, 32'h1, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sdram_pattern_master.md
SDRAM_PATTERN_MASTER -- requirements
Module: sdram_pattern_master

Interface
REQ-001 SHALL have parameter MAX_PEND, default 4, maximum outstanding read transactions (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 24, width of the word-count and index counters.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
REQ-004 SHALL have the control ports:
- start  in  1  one-cycle request to run a test
- base_addr  in  28  byte base address (bits [1:0] ignored, treated as 0)
- word_count  in  CNT_W  number of 32-bit words
- seed  in  32  pattern seed
- busy  out  1  test in progress
- done  out  1  test finished, held until next accepted start
- pass  out  1  valid while done, 1 = zero mismatches
- err_count  out  16  mismatch count, saturating
- first_err_addr  out  28  byte address of first mismatch
REQ-005 SHALL have the Avalon-MM master ports:
- sdout_address  out  28  byte address
- sdout_read  out  1  read request
- sdout_write  out  1  write request
- sdout_writedata  out  32  write data
- sdout_byteenable  out  4  constant 4'hF
- sdout_burstcount  out  1  constant 1
- sdout_debugaccess  out  1  constant 0
- sdout_waitrequest  in  1  slave stall
- sdout_readdata  in  32  read data
- sdout_readdatavalid  in  1  read data strobe

Function
REQ-006 SHALL use word i at byte address (base_addr[27:2]*4 + 4*i) mod 2^28, so addresses wrap silently at 2^28.
REQ-007 SHALL write the pattern P(i) = seed XOR {i zero-extended to 32 bits} XOR {i[15:0], i[15:0]} bitwise.
REQ-008 SHALL use the FSM states IDLE, WRITE, READ, DRAIN and FIN.
REQ-009 In IDLE, start SHALL clear err_count, first_err_addr, done and pass, set busy, and go to WRITE; if word_count==0 it SHALL go directly to FIN.
REQ-010 In WRITE, the block SHALL hold sdout_write, address and writedata stable while sdout_waitrequest=1; a cycle with write=1 and waitrequest=0 counts as accepted and advances the index.
REQ-011 After accepting word word_count-1, WRITE SHALL deassert write on the next cycle and go to READ with the issue index reset to 0.
REQ-012 In READ, sdout_read SHALL assert only while pending<MAX_PEND; an accepted read increments pending, and readdatavalid decrements it.
REQ-013 When an accepted read and readdatavalid occur in the same cycle, pending SHALL stay unchanged.
REQ-014 Read data SHALL be compared in order against P(return index), and a separate return-index counter SHALL advance on each readdatavalid.
REQ-015 On a mismatch, err_count SHALL increment, saturating at 16'hFFFF, and the first mismatch SHALL latch the byte address of the return index.
REQ-016 After the last read is accepted, the block SHALL go to DRAIN; when pending==0, it SHALL go to FIN.
REQ-017 FIN SHALL, in one cycle, set done=1, busy=0 and pass=(err_count==0), then return to IDLE with done and pass held.
REQ-018 A start received while busy=1 SHALL be ignored.
REQ-019 sdout_read and sdout_write SHALL never be asserted in the same cycle.
REQ-020 A readdatavalid received with pending==0 SHALL be ignored and SHALL NOT be counted as an error.
REQ-021 The block SHALL latch base_addr, word_count and seed at start; later changes to these inputs SHALL NOT affect the running test.

Reset
REQ-022 On reset the block SHALL set: state=IDLE, all counters 0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, sdout_read=0, sdout_write=0, sdout_address=0, sdout_writedata=0.
REQ-023 Reset mid-transaction SHALL drop read and write on the next edge; the slave is reset by the same reset, so the protocol violation this causes is permitted.

Structure
REQ-024 A shared package sdram_pkg SHALL hold the state enumeration, the address width (28) and data width (32) constants, and the pattern function P.
REQ-025 The compare path (expected-pattern generation, error counter and first-error latch) SHALL be one sub-module, sdram_pattern_checker.

Verification
REQ-026 Run with base=0x0000100, count=8, seed=0xA5A5A5A5 and a zero-wait memory model -> writes to 0x100..0x11C, then reads; done=1, pass=1, err_count=0.
REQ-027 Same run with the model asserting waitrequest for 3 cycles on every command -> identical memory contents; address and writedata stable during stalls; pass=1.
REQ-028 Model corrupts the word at 0x108 (bit 0 flipped) and the word at 0x110 -> err_count=2, first_err_addr=0x108, pass=0.
REQ-029 Model with readdatavalid latency of 5 cycles and MAX_PEND=4 -> pending never exceeds 4; count=16 completes with pass=1.
REQ-030 base=0xFFFFFF8, count=4 -> addresses 0xFFFFFF8, 0xFFFFFFC, 0x0000000, 0x0000004; pass=1.
REQ-031 Edge cases, each checked separately:
- count=0 -> done two cycles after start, pass=1, no bus activity.
- start pulsed while busy -> ignored.
- reset asserted mid-READ -> all outputs reach their reset values one cycle later.
